// File: rtl/minesweeper_pkg.sv
// Shared constants for the minesweeper board: grid geometry, cursor start square,
// game condition encoding and the button index map used by the cursor front end.
package minesweeper_pkg;

    localparam int GRID_DIM = 16;
    localparam int ADDR_W   = 8;
    localparam int COORD_W  = 4;

    localparam logic [COORD_W-1:0] START_X = 4'd8;
    localparam logic [COORD_W-1:0] START_Y = 4'd8;

    typedef enum logic [1:0] {
        COND_PLAY = 2'b00,
        COND_WIN  = 2'b01,
        COND_LOSE = 2'b10
    } cond_e;

    // Button slots; directions come first so they can share the repeat-enable test.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;
    localparam int BTN_FLAG  = 5;
    localparam int NUM_DIR   = 4;
    localparam int NUM_BTNS  = 6;

    // One step along an axis; opposite requests cancel, 4-bit arithmetic wraps the board edge.
    function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                      input logic inc,
                                                      input logic dec);
        logic [COORD_W-1:0] r;
        r = c;
        if (inc && !dec) r = c + COORD_W'(1);
        if (dec && !inc) r = c - COORD_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/cursor_ctrl_btn_debounce.sv
// One raw button: 2-FF synchroniser, counter debouncer, press-edge event and,
// for direction buttons, a hold-to-repeat timer that restarts on every press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic rpt
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    logic            sync_p0;
    logic            sync_p1;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rpt_cnt;
    logic [RP_W-1:0] rpt_target;
    logic            rpt_first;

    // stage p0/p1: metastability guard for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
        end
    end

    // stable follows the synchronised level only after it has disagreed for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            stable_d <= stable;
            if (sync_p1 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press      = stable & ~stable_d;
    assign rpt_target = rpt_first ? RP_W'(REPEAT_DELAY) : RP_W'(REPEAT_RATE);
    assign rpt        = REPEAT_EN && stable && !press && (rpt_cnt == rpt_target);

    // rpt_cnt holds the cycles elapsed since the press or the previous repeat
    always_ff @(posedge clk) begin
        if (rst || !REPEAT_EN || !stable) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (press || rpt) begin
            rpt_cnt   <= RP_W'(1);
            rpt_first <= press;
        end else begin
            rpt_cnt <= rpt_cnt + RP_W'(1);
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// Board cursor front end: six debounced buttons drive a wrapping 16x16 cursor
// and one-cycle reveal/flag pulses for play_state.
module cursor_ctrl
    import minesweeper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_sel,
    input  logic                btn_flag,
    output logic [COORD_W-1:0]  cursor_x,
    output logic [COORD_W-1:0]  cursor_y,
    output logic [ADDR_W-1:0]   cursor_addr,
    output logic                sel_sqr,
    output logic                place_flag
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] rpt;
    logic [NUM_BTNS-1:0] ev;
    logic                enable_d;
    logic                enable_rise;
    logic [COORD_W-1:0]  x_nxt;
    logic [COORD_W-1:0]  y_nxt;
    logic                sel_nxt;
    logic                flag_nxt;

    assign btn_raw = {btn_flag, btn_sel, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (i < NUM_DIR)
        ) u_btn (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[i]),
            .press (press[i]),
            .rpt   (rpt[i])
        );
    end

    assign ev          = press | rpt;
    assign enable_rise = enable & ~enable_d;

    always_comb begin
        x_nxt    = cursor_x;
        y_nxt    = cursor_y;
        sel_nxt  = 1'b0;
        flag_nxt = 1'b0;
        if (enable_rise) begin
            // entering play recentres and swallows whatever event lands on this cycle
            x_nxt = START_X;
            y_nxt = START_Y;
        end else if (enable) begin
            y_nxt    = step_coord(cursor_y, ev[BTN_DOWN], ev[BTN_UP]);
            x_nxt    = step_coord(cursor_x, ev[BTN_RIGHT], ev[BTN_LEFT]);
            sel_nxt  = ev[BTN_SEL];
            flag_nxt = ev[BTN_FLAG] & ~ev[BTN_SEL];
        end
    end

    // output stage: address and pulses share one edge so a pulse always sees the new square
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x    <= START_X;
            cursor_y    <= START_Y;
            cursor_addr <= {START_Y, START_X};
            sel_sqr     <= 1'b0;
            place_flag  <= 1'b0;
            enable_d    <= 1'b0;
        end else begin
            cursor_x    <= x_nxt;
            cursor_y    <= y_nxt;
            cursor_addr <= {y_nxt, x_nxt};
            sel_sqr     <= sel_nxt;
            place_flag  <= flag_nxt;
            enable_d    <= enable;
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: directed board scenarios plus random button traffic,
// every cycle compared against a timeline model of debounce, repeat and cursor rules.
module tb_cursor_ctrl;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel, btn_flag;
    logic [3:0] cursor_x, cursor_y;
    logic [7:0] cursor_addr;
    logic       sel_sqr, place_flag;

    cursor_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_sel     (btn_sel),
        .btn_flag    (btn_flag),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_addr (cursor_addr),
        .sel_sqr     (sel_sqr),
        .place_flag  (place_flag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each button is a timeline of raw samples; the synchronised level at edge k is raw(k-2),
    // and the debounced level flips when the DB samples before it all hold the new value.
    logic [5:0] btns;
    assign btns = {btn_flag, btn_sel, btn_right, btn_left, btn_down, btn_up};

    bit raw_h[6][16];
    bit st[6];
    bit st_prev[6];
    int pe[6];
    int cyc = 16;
    bit en_prev;
    int mx = 8, my = 8;
    bit msel, mflag;
    bit m_ev[6];
    int m_age;
    bit m_same;
    bit m_v;

    always @(posedge clk) begin
        for (int b = 0; b < 6; b++) begin
            m_age   = cyc - 1 - pe[b];
            m_ev[b] = st[b] && (!st_prev[b] ||
                      (b < 4 && pe[b] >= 0 && m_age >= RD && ((m_age - RD) % RR) == 0));
        end
        if (rst) begin
            mx = 8; my = 8; msel = 0; mflag = 0; en_prev = 0;
            for (int b = 0; b < 6; b++) begin
                for (int j = 0; j < 16; j++) raw_h[b][j] = 0;
                st[b] = 0; st_prev[b] = 0; pe[b] = -1;
            end
        end else begin
            if (enable && !en_prev) begin
                mx = 8; my = 8; msel = 0; mflag = 0;
            end else if (enable) begin
                if (m_ev[1] && !m_ev[0]) my = (my + 1) % 16;
                else if (m_ev[0] && !m_ev[1]) my = (my + 15) % 16;
                if (m_ev[3] && !m_ev[2]) mx = (mx + 1) % 16;
                else if (m_ev[2] && !m_ev[3]) mx = (mx + 15) % 16;
                msel  = m_ev[4];
                mflag = m_ev[5] && !m_ev[4];
            end else begin
                msel = 0; mflag = 0;
            end
            en_prev = enable;
            for (int b = 0; b < 6; b++) begin
                raw_h[b][cyc % 16] = btns[b];
                m_v    = raw_h[b][(cyc - 2) % 16];
                m_same = 1;
                for (int j = 0; j < DB; j++)
                    if (raw_h[b][(cyc - 2 - j) % 16] != m_v) m_same = 0;
                st_prev[b] = st[b];
                if (m_same && m_v != st[b]) st[b] = m_v;
                if (st[b] && !st_prev[b]) pe[b] = cyc;
                else if (!st[b]) pe[b] = -1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("cursor_x", int'(cursor_x), mx);
        chk("cursor_y", int'(cursor_y), my);
        chk("cursor_addr", int'(cursor_addr), my * 16 + mx);
        chk("sel_sqr", int'(sel_sqr), int'(msel));
        chk("place_flag", int'(place_flag), int'(mflag));
    end

    // ---------------- stimulus ----------------
    int nsel, nflag;

    task automatic drive(input logic [5:0] v);
        {btn_flag, btn_sel, btn_right, btn_left, btn_down, btn_up} = v;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (sel_sqr) nsel++;
            if (place_flag) nflag++;
        end
    endtask

    task automatic press_btns(input logic [5:0] v, input int hold);
        drive(v);
        run(hold);
        drive(6'b0);
        run(10);
    endtask

    task automatic recentre();
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(1);
        chk("recentre_addr", int'(cursor_addr), 136);
    endtask

    int first_sel;
    logic [5:0] rv;
    int hold;

    initial begin
        rst = 1'b1; enable = 1'b1;
        drive(6'b010000);
        run(2);
        chk("reset_addr", int'(cursor_addr), 136);
        chk("reset_sel", int'(sel_sqr), 0);
        chk("reset_flag", int'(place_flag), 0);

        // select held through reset fires once, seven edges after release
        rst = 1'b0; nsel = 0; first_sel = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sel_sqr) begin
                nsel++;
                if (first_sel == 0) first_sel = n;
            end
        end
        chk("held_sel_count", nsel, 1);
        chk("held_sel_latency", first_sel, 7);
        drive(6'b0);
        run(10);

        // bounce then a clean hold
        for (int i = 0; i < 6; i++) begin
            btn_right = ~btn_right;
            run(2);
        end
        btn_right = 1'b1;
        run(15);
        btn_right = 1'b0;
        run(10);
        chk("bounce_x", int'(cursor_x), 9);
        chk("bounce_addr", int'(cursor_addr), 137);
        btn_right = 1'b1;
        run(3);
        btn_right = 1'b0;
        run(10);
        chk("glitch_addr", int'(cursor_addr), 137);

        // wrap-around on both axes
        for (int i = 0; i < 6; i++) press_btns(6'b001000, 8);
        chk("x_at_15", int'(cursor_x), 15);
        press_btns(6'b001000, 8);
        chk("wrap_right", int'(cursor_x), 0);
        for (int i = 0; i < 9; i++) press_btns(6'b000001, 8);
        chk("wrap_up_y", int'(cursor_y), 15);
        chk("wrap_up_addr", int'(cursor_addr), 240);

        // auto-repeat on a held direction, none on select
        recentre();
        press_btns(6'b000010, 60);
        run(2);
        chk("repeat_y", int'(cursor_y), 14);
        chk("repeat_addr", int'(cursor_addr), 232);
        nsel = 0;
        press_btns(6'b010000, 60);
        chk("sel_no_repeat", nsel, 1);

        // simultaneous presses
        recentre();
        press_btns(6'b000011, 8);
        chk("up_down_addr", int'(cursor_addr), 136);
        press_btns(6'b001001, 8);
        chk("diag_addr", int'(cursor_addr), 121);
        nsel = 0; nflag = 0;
        press_btns(6'b110000, 8);
        chk("sel_flag_sel", nsel, 1);
        chk("sel_flag_flag", nflag, 0);

        // enable gating
        enable = 1'b0;
        nsel = 0; nflag = 0;
        press_btns(6'b101000, 8);
        chk("disabled_addr", int'(cursor_addr), 121);
        chk("disabled_flag", nflag, 0);
        recentre();
        for (int i = 0; i < 8; i++) press_btns(6'b000001, 8);
        for (int i = 0; i < 8; i++) press_btns(6'b000100, 8);
        chk("origin_addr", int'(cursor_addr), 0);
        enable = 1'b0;
        drive(6'b100000);
        run(10);
        nflag = 0;
        enable = 1'b1;
        run(1);
        chk("rise_addr", int'(cursor_addr), 136);
        chk("rise_flag", int'(place_flag), 0);
        run(20);
        chk("held_flag_quiet", nflag, 0);
        drive(6'b0);
        run(10);
        press_btns(6'b100000, 8);
        chk("flag_repress", nflag, 1);

        // random traffic, including mid-hold resets and enable drops
        for (int it = 0; it < 150; it++) begin
            rv     = 6'($urandom) & 6'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            hold   = $urandom_range(1, 40);
            drive(rv);
            run(hold / 2);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
            run(hold - hold / 2);
            drive(6'b0);
            run($urandom_range(0, 10));
        end
        run(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
